pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the dual-issue 5-stage pipeline.

---
 rtl/cpu_ctrl_pkg.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: stage indices, FSM states,
// exception kinds and the flush pattern each kind imposes on the stage registers.
package cpu_ctrl_pkg;

    localparam int STG_FD = 0;
    localparam int STG_DE = 1;
    localparam int STG_EM = 2;
    localparam int STG_MW = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        REFILL   = 2'd2
    } hctl_state_t;

    typedef enum logic [1:0] {
        EK_MASTER = 2'd0,
        EK_SLAVE  = 2'd1,
        EK_ERET   = 2'd2
    } exc_kind_t;

    typedef struct packed {
        logic [3:0] ena_m;
        logic [3:0] ena_s;
        logic [3:0] clr_m;
        logic [3:0] clr_s;
    } stage_ctl_t;

    // A slave-only exception lets the older master instruction retire from MW.
    function automatic stage_ctl_t flush_pattern(input exc_kind_t kind);
        stage_ctl_t f;
        f.ena_m = 4'b0000;
        f.ena_s = 4'b0000;
        f.clr_m = 4'b1111;
        f.clr_s = 4'b1111;
        if (kind == EK_SLAVE) begin
            f.clr_m[STG_MW] = 1'b0;
            f.ena_m[STG_MW] = 1'b1;
        end
        return f;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the dual-issue 5-stage pipeline: per-slot enable/clear
// of FD/DE/EM/MW, the PC redirect pulse, and fetch bubbles during I-side refill.
module pipe_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int REFILL_CYCLES = 2,
    parameter int CNT_W         = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_stall,
    input  logic       d_stall,
    input  logic       div_busy,
    input  logic       lu_hazard,
    input  logic       M_master_exc,
    input  logic       M_slave_exc,
    input  logic       M_master_eret,
    output logic [3:0] ena_m,
    output logic [3:0] ena_s,
    output logic [3:0] clr_m,
    output logic [3:0] clr_s,
    output logic       redirect,
    output logic       redirect_eret
);

    hctl_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    exc_kind_t kind_q, kind_d;

    logic mem_stall;
    logic exc;
    exc_kind_t live_kind;
    stage_ctl_t flush;

    assign mem_stall = i_stall | d_stall;
    assign exc       = M_master_exc | M_slave_exc | M_master_eret;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        kind_d        = kind_q;
        ena_m         = 4'b0000;
        ena_s         = 4'b0000;
        clr_m         = 4'b0000;
        clr_s         = 4'b0000;
        redirect      = 1'b0;
        redirect_eret = 1'b0;

        if (M_master_exc)       live_kind = EK_MASTER;
        else if (M_master_eret) live_kind = EK_ERET;
        else                    live_kind = EK_SLAVE;

        flush = flush_pattern(state_q == WAIT_MEM ? kind_q : live_kind);

        if (rst) begin
            clr_m   = 4'b1111;
            clr_s   = 4'b1111;
            state_d = RUN;
            cnt_d   = '0;
            kind_d  = EK_MASTER;
        end else begin
            case (state_q)
                RUN: begin
                    if (exc && mem_stall) begin
                        kind_d  = live_kind;
                        state_d = WAIT_MEM;
                    end else if (exc) begin
                        {ena_m, ena_s, clr_m, clr_s} = flush;
                        redirect      = 1'b1;
                        redirect_eret = (live_kind == EK_ERET);
                        cnt_d         = CNT_W'(REFILL_CYCLES);
                        state_d       = REFILL;
                    end else if (mem_stall) begin
                        ena_m = 4'b0000;
                    end else if (div_busy) begin
                        clr_m[STG_MW] = 1'b1;
                        clr_s[STG_MW] = 1'b1;
                    end else if (lu_hazard) begin
                        clr_m[STG_DE] = 1'b1;
                        clr_s[STG_DE] = 1'b1;
                        ena_m[STG_EM] = 1'b1;
                        ena_s[STG_EM] = 1'b1;
                        ena_m[STG_MW] = 1'b1;
                        ena_s[STG_MW] = 1'b1;
                    end else begin
                        ena_m = 4'b1111;
                        ena_s = 4'b1111;
                    end
                end
                WAIT_MEM: begin
                    if (!mem_stall) begin
                        {ena_m, ena_s, clr_m, clr_s} = flush;
                        redirect      = 1'b1;
                        redirect_eret = (kind_q == EK_ERET);
                        cnt_d         = CNT_W'(REFILL_CYCLES);
                        state_d       = REFILL;
                    end
                end
                REFILL: begin
                    // Exceptions are ignored: everything behind the redirect is already bubbles.
                    clr_m[STG_FD] = 1'b1;
                    clr_s[STG_FD] = 1'b1;
                    if (!d_stall) begin
                        ena_m[3:1] = 3'b111;
                        ena_s[3:1] = 3'b111;
                    end
                    if (!i_stall) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        kind_q  <= kind_d;
    end

    assert property (@(posedge clk) ((ena_m & clr_m) == 4'b0000) && ((ena_s & clr_s) == 4'b0000));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; each vector carries a hand-computed
// expectation for {redirect_eret, redirect, clr_s, clr_m, ena_s, ena_m}.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic i_stall, d_stall, div_busy, lu_hazard;
    logic M_master_exc, M_slave_exc, M_master_eret;
    logic [3:0] ena_m, ena_s, clr_m, clr_s;
    logic redirect, redirect_eret;

    int vec_count = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .i_stall       (i_stall),
        .d_stall       (d_stall),
        .div_busy      (div_busy),
        .lu_hazard     (lu_hazard),
        .M_master_exc  (M_master_exc),
        .M_slave_exc   (M_slave_exc),
        .M_master_eret (M_master_eret),
        .ena_m         (ena_m),
        .ena_s         (ena_s),
        .clr_m         (clr_m),
        .clr_s         (clr_s),
        .redirect      (redirect),
        .redirect_eret (redirect_eret)
    );

    // Bundle layout: {eret, redir, clr_s, clr_m, ena_s, ena_m}
    function automatic logic [17:0] exp_v(input logic [3:0] em, input logic [3:0] es,
                                          input logic [3:0] cm, input logic [3:0] cs,
                                          input logic rd, input logic er);
        return {er, rd, cs, cm, es, em};
    endfunction

    task automatic checkOutput(input string tag, input logic [17:0] got, input logic [17:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got eret=%b redir=%b clr_s=%h clr_m=%h ena_s=%h ena_m=%h, expected eret=%b redir=%b clr_s=%h clr_m=%h ena_s=%h ena_m=%h",
                     tag, got[17], got[16], got[15:12], got[11:8], got[7:4], got[3:0],
                     exp[17], exp[16], exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
        end
    endtask

    // Drive on the falling edge, then sample the combinational outputs 1 time unit later.
    task automatic applyStimulus(input logic r, input logic is, input logic ds, input logic dv,
                                 input logic lu, input logic mx, input logic sx, input logic me,
                                 input string tag, input logic [17:0] exp);
        @(negedge clk);
        rst = r; i_stall = is; d_stall = ds; div_busy = dv;
        lu_hazard = lu; M_master_exc = mx; M_slave_exc = sx; M_master_eret = me;
        #1;
        checkOutput(tag, {redirect_eret, redirect, clr_s, clr_m, ena_s, ena_m}, exp);
    endtask

    logic [17:0] e_idle, e_frz, e_refill, e_rst, e_mflush;

    initial begin
        rst = 1'b1; i_stall = 0; d_stall = 0; div_busy = 0;
        lu_hazard = 0; M_master_exc = 0; M_slave_exc = 0; M_master_eret = 0;

        e_idle   = exp_v(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
        e_frz    = exp_v(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        e_refill = exp_v(4'hE, 4'hE, 4'h1, 4'h1, 1'b0, 1'b0);
        e_rst    = exp_v(4'h0, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0);
        e_mflush = exp_v(4'h0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0);

        applyStimulus(1, 0,0,0,0, 0,0,0, "reset0", e_rst);
        applyStimulus(1, 0,0,0,0, 0,0,0, "reset1", e_rst);

        for (int i = 0; i < 5; i++)
            applyStimulus(0, 0,0,0,0, 0,0,0, $sformatf("idle%0d", i), e_idle);

        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0,1,1,0, 0,0,0, $sformatf("dstall_div%0d", i), e_frz);
        applyStimulus(0, 0,0,1,0, 0,0,0, "div_bubble", exp_v(4'h0, 4'h0, 4'h8, 4'h8, 1'b0, 1'b0));
        applyStimulus(0, 0,0,0,1, 0,0,0, "lu_hazard", exp_v(4'hC, 4'hC, 4'h2, 4'h2, 1'b0, 1'b0));
        applyStimulus(0, 1,0,0,0, 0,0,0, "istall_run", e_frz);

        applyStimulus(0, 0,0,0,0, 0,1,0, "slave_exc", exp_v(4'h8, 4'h0, 4'h7, 4'hF, 1'b1, 1'b0));
        applyStimulus(0, 0,0,0,0, 0,0,0, "slave_refill0", e_refill);
        applyStimulus(0, 0,0,0,0, 0,0,0, "slave_refill1", e_refill);
        applyStimulus(0, 0,0,0,0, 0,0,0, "slave_run", e_idle);

        for (int i = 0; i < 4; i++)
            applyStimulus(0, 0,1,0,0, 0,0,1, $sformatf("eret_wait%0d", i), e_frz);
        applyStimulus(0, 0,0,0,0, 0,0,1, "eret_redirect", exp_v(4'h0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b1));
        applyStimulus(0, 0,0,0,0, 0,0,0, "eret_refill0", e_refill);
        applyStimulus(0, 0,0,0,0, 0,0,0, "eret_refill1", e_refill);
        applyStimulus(0, 0,0,0,0, 0,0,0, "eret_run", e_idle);

        applyStimulus(0, 0,0,0,0, 1,0,0, "master_exc", e_mflush);
        applyStimulus(0, 1,0,0,0, 0,0,0, "refill_istall0", e_refill);
        applyStimulus(0, 1,0,0,0, 1,1,0, "refill_istall_exc", e_refill);
        applyStimulus(0, 1,0,0,0, 0,0,0, "refill_istall2", e_refill);
        applyStimulus(0, 0,0,0,0, 0,0,1, "refill_cnt2_eret", e_refill);
        applyStimulus(0, 0,1,0,0, 0,0,0, "refill_cnt1_dstall", exp_v(4'h0, 4'h0, 4'h1, 4'h1, 1'b0, 1'b0));
        applyStimulus(0, 0,0,0,0, 0,0,0, "refill_done", e_idle);

        applyStimulus(0, 0,0,0,0, 1,1,0, "master_and_slave", e_mflush);
        applyStimulus(0, 0,0,0,0, 0,0,0, "ms_refill0", e_refill);
        applyStimulus(0, 0,0,0,0, 0,0,0, "ms_refill1", e_refill);
        applyStimulus(0, 0,0,0,0, 0,1,1, "eret_and_slave", exp_v(4'h0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b1));
        applyStimulus(0, 0,0,0,0, 0,0,0, "es_refill0", e_refill);
        applyStimulus(0, 0,0,0,0, 0,0,0, "es_refill1", e_refill);
        applyStimulus(0, 0,0,0,0, 0,0,0, "es_run", e_idle);

        applyStimulus(0, 1,0,0,0, 1,0,0, "exc_istall_wait", e_frz);
        applyStimulus(0, 1,0,0,0, 1,0,0, "wait_mem", e_frz);
        applyStimulus(1, 1,0,0,0, 1,0,0, "rst_in_wait", e_rst);
        applyStimulus(0, 0,0,0,0, 0,0,0, "post_rst_run0", e_idle);
        applyStimulus(0, 0,0,0,0, 0,0,0, "post_rst_run1", e_idle);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
